// File: rtl/u_rx_ctrl.sv
// UART receive-side controller: baud tick divider, 8-bit FWFT byte FIFO with sticky overrun, idle-line timeout.
// All outputs registered; push visible next cycle; a byte arriving while full with no pop is dropped and flagged.
module u_rx_ctrl #(
  parameter int DIV_W      = 16,
  parameter int DEPTH      = 4,
  parameter int IDLE_TICKS = 320
) (
  input  logic                   sys_clk,
  input  logic                   sys_rstH,
  input  logic                   enableH,
  input  logic [DIV_W-1:0]       baud_divH,
  output logic                   EN_clk,
  input  logic [7:0]             rec_dataH,
  input  logic                   rec_readyH,
  input  logic                   rd_reqH,
  output logic [7:0]             rd_dataH,
  output logic                   rd_validH,
  output logic [$clog2(DEPTH):0] countH,
  output logic                   overrunH,
  input  logic                   clr_errH,
  input  logic                   flushH,
  output logic                   idle_toH
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(IDLE_TICKS + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(IDLE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {T_IDLE, T_ARMED, T_FIRE} tstate_e;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             en_clk_q, en_clk_d;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             vld_q, overrun_q, overrun_d;
  logic             full, pop, push_ok, drop;

  tstate_e          state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             fire_q;

  // >= rather than == so a divisor lowered mid-count ticks immediately instead of wrapping
  always_comb begin
    div_cnt_d = '0;
    en_clk_d  = 1'b0;
    if (enableH) begin
      if (div_cnt_q >= baud_divH) begin
        en_clk_d = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  assign full    = (count_q == CNT_FULL);
  assign pop     = rd_reqH && (count_q != '0) && !flushH;
  assign push_ok = rec_readyH && !flushH && (!full || pop);
  assign drop    = rec_readyH && !flushH && full && !pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (flushH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push_ok) count_d = count_q - CNT_W'(1);
    end
    if (drop)          overrun_d = 1'b1;
    else if (clr_errH) overrun_d = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rec_dataH;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      T_IDLE: begin
        timer_d = '0;
        if (push_ok) state_d = T_ARMED;
      end
      T_ARMED: begin
        if (push_ok) begin
          timer_d = '0;
        end else if (en_clk_q) begin
          if (timer_q == TMR_LAST) begin
            state_d = T_FIRE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      T_FIRE: begin
        timer_d = '0;
        state_d = push_ok ? T_ARMED : T_IDLE;
      end
      default: begin
        state_d = T_IDLE;
        timer_d = '0;
      end
    endcase
    if (!enableH || flushH) begin
      state_d = T_IDLE;
      timer_d = '0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rstH) begin
    if (sys_rstH) begin
      div_cnt_q <= '0;
      en_clk_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      vld_q     <= 1'b0;
      overrun_q <= 1'b0;
      state_q   <= T_IDLE;
      timer_q   <= '0;
      fire_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      en_clk_q  <= en_clk_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      vld_q     <= (count_d != '0);
      overrun_q <= overrun_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      fire_q    <= (state_d == T_FIRE);
    end
  end

  assign EN_clk    = en_clk_q;
  assign rd_dataH  = mem_q[rd_ptr_q];
  assign rd_validH = vld_q;
  assign countH    = count_q;
  assign overrunH  = overrun_q;
  assign idle_toH  = fire_q;

endmodule

// File: tb/tb_u_rx_ctrl.sv
// Bench for u_rx_ctrl: FIFO vector table with a byte scoreboard, plus divider, idle-timeout and reset sequences.
module tb_u_rx_ctrl;

  logic       sys_clk, sys_rstH, enableH;
  logic [15:0] baud_divH;
  logic       EN_clk;
  logic [7:0] rec_dataH, rd_dataH;
  logic       rec_readyH, rd_reqH, rd_validH, overrunH, clr_errH, flushH, idle_toH;
  logic [2:0] countH;

  u_rx_ctrl #(.DIV_W(16), .DEPTH(4), .IDLE_TICKS(8)) dut (
    .sys_clk(sys_clk), .sys_rstH(sys_rstH), .enableH(enableH), .baud_divH(baud_divH),
    .EN_clk(EN_clk), .rec_dataH(rec_dataH), .rec_readyH(rec_readyH), .rd_reqH(rd_reqH),
    .rd_dataH(rd_dataH), .rd_validH(rd_validH), .countH(countH), .overrunH(overrunH),
    .clr_errH(clr_errH), .flushH(flushH), .idle_toH(idle_toH)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       rdy;
    logic [7:0] dat;
    logic       rd;
    logic       flush;
    logic       clr;
    logic [2:0] e_cnt;
    logic       e_vld;
    logic       e_ovr;
  } vec_t;

  localparam int NV = 25;
  vec_t vec [NV];
  logic [7:0] sbq [$];
  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rec_readyH = 1'b1;
    rec_dataH  = b;
    step();
    rec_readyH = 1'b0;
  endtask

  initial begin
    int pre;
    logic popped;
    vec[0]  = '{1, 8'h11, 0, 0, 0, 3'd1, 1, 0};
    vec[1]  = '{1, 8'h22, 0, 0, 0, 3'd2, 1, 0};
    vec[2]  = '{1, 8'h33, 0, 0, 0, 3'd3, 1, 0};
    vec[3]  = '{1, 8'h44, 0, 0, 0, 3'd4, 1, 0};
    vec[4]  = '{1, 8'h55, 0, 0, 0, 3'd4, 1, 1};
    vec[5]  = '{1, 8'h66, 1, 0, 0, 3'd4, 1, 1};
    vec[6]  = '{0, 8'h00, 0, 0, 1, 3'd4, 1, 0};
    vec[7]  = '{0, 8'h00, 1, 0, 0, 3'd3, 1, 0};
    vec[8]  = '{0, 8'h00, 1, 0, 0, 3'd2, 1, 0};
    vec[9]  = '{0, 8'h00, 1, 0, 0, 3'd1, 1, 0};
    vec[10] = '{0, 8'h00, 1, 0, 0, 3'd0, 0, 0};
    vec[11] = '{0, 8'h00, 1, 0, 0, 3'd0, 0, 0};
    vec[12] = '{1, 8'h77, 1, 0, 0, 3'd1, 1, 0};
    vec[13] = '{1, 8'h88, 0, 0, 0, 3'd2, 1, 0};
    vec[14] = '{1, 8'h99, 0, 0, 0, 3'd3, 1, 0};
    vec[15] = '{1, 8'hAA, 0, 0, 0, 3'd4, 1, 0};
    vec[16] = '{1, 8'hBB, 0, 0, 1, 3'd4, 1, 1};
    vec[17] = '{0, 8'h00, 0, 0, 1, 3'd4, 1, 0};
    vec[18] = '{0, 8'h00, 1, 0, 0, 3'd3, 1, 0};
    vec[19] = '{0, 8'h00, 1, 0, 0, 3'd2, 1, 0};
    vec[20] = '{0, 8'h00, 1, 0, 0, 3'd1, 1, 0};
    vec[21] = '{0, 8'h00, 1, 0, 0, 3'd0, 0, 0};
    vec[22] = '{1, 8'hCC, 0, 0, 0, 3'd1, 1, 0};
    vec[23] = '{1, 8'hDD, 0, 1, 0, 3'd0, 0, 0};
    vec[24] = '{1, 8'hEE, 1, 1, 0, 3'd0, 0, 0};

    sys_rstH = 1'b1; enableH = 1'b0; baud_divH = 16'd0; rec_dataH = 8'h00;
    rec_readyH = 1'b0; rd_reqH = 1'b0; clr_errH = 1'b0; flushH = 1'b0;
    #3;
    check("rst EN_clk", EN_clk, 0);
    check("rst rd_validH", rd_validH, 0);
    check("rst countH", countH, 0);
    check("rst overrunH", overrunH, 0);
    check("rst idle_toH", idle_toH, 0);
    step(); step();
    sys_rstH = 1'b0;

    // FIFO vectors with enableH low: pushes must still land
    for (int i = 0; i < NV; i++) begin
      rec_readyH = vec[i].rdy; rec_dataH = vec[i].dat; rd_reqH = vec[i].rd;
      flushH = vec[i].flush; clr_errH = vec[i].clr;
      pre = sbq.size();
      popped = vec[i].rd && !vec[i].flush && (pre > 0);
      if (popped) check($sformatf("vec%0d pop data", i), rd_dataH, sbq.pop_front());
      if (vec[i].flush) sbq.delete();
      else if (vec[i].rdy && (pre < 4 || popped)) sbq.push_back(vec[i].dat);
      step();
      check($sformatf("vec%0d countH", i), countH, vec[i].e_cnt);
      check($sformatf("vec%0d rd_validH", i), rd_validH, vec[i].e_vld);
      check($sformatf("vec%0d overrunH", i), overrunH, vec[i].e_ovr);
      if (vec[i].e_vld && sbq.size() > 0) check($sformatf("vec%0d head", i), rd_dataH, sbq[0]);
    end
    rec_readyH = 0; rd_reqH = 0; flushH = 0; clr_errH = 0;

    // Divider: period 4, then divisor lowered mid-count, then disabled
    baud_divH = 16'd3; enableH = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step();
      check($sformatf("div3 cyc%0d", i), EN_clk, (i % 4 == 0));
    end
    baud_divH = 16'd1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("div1 cyc%0d", k), EN_clk, (k % 2 == 0));
    end
    enableH = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("div off cyc%0d", k), EN_clk, 0);
    end

    // Idle timeout with a tick every cycle
    baud_divH = 16'd0; enableH = 1'b1;
    step(); step();
    push_byte(8'hA5);
    for (int j = 1; j <= 12; j++) begin
      step();
      check($sformatf("idle pulse j%0d", j), idle_toH, (j == 8));
    end
    push_byte(8'hB6);
    for (int j = 1; j <= 5; j++) begin
      step();
      check($sformatf("restart pre j%0d", j), idle_toH, 0);
    end
    push_byte(8'hC7);
    check("restart at push", idle_toH, 0);
    for (int j = 1; j <= 12; j++) begin
      step();
      check($sformatf("restart post j%0d", j), idle_toH, (j == 8));
    end
    check("idle fifo count", countH, 3);
    check("idle fifo head", rd_dataH, 8'hA5);
    push_byte(8'hD8);
    step(); step(); step();
    flushH = 1'b1;
    step();
    flushH = 1'b0;
    check("flush count", countH, 0);
    for (int j = 1; j <= 12; j++) begin
      step();
      check($sformatf("flush nopulse j%0d", j), idle_toH, 0);
    end

    // Asynchronous reset between clock edges
    for (int j = 0; j < 5; j++) push_byte(8'h30 + 8'(j));
    check("pre-rst overrunH", overrunH, 1);
    check("pre-rst EN_clk", EN_clk, 1);
    check("pre-rst countH", countH, 4);
    #2 sys_rstH = 1'b1;
    #1;
    check("async EN_clk", EN_clk, 0);
    check("async rd_validH", rd_validH, 0);
    check("async countH", countH, 0);
    check("async overrunH", overrunH, 0);
    check("async idle_toH", idle_toH, 0);
    step();
    sys_rstH = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/u_rx_ctrl.md
# u_rx_ctrl

Receive-side controller for the UART receiver. It generates the receiver's oversampling enable (`EN_clk`) from a programmable divisor and captures each `rec_readyH`/`rec_dataH` byte into a small first-word-fall-through FIFO. It flags overrun and runs an idle-line timeout so the consumer can drain short messages. It sits between the UART receiver and the host-side consumer logic, on the same `sys_clk`.

## Interface

Parameters:
- `DIV_W`, 16, width of the baud divisor.
- `DEPTH`, 4, FIFO depth; power of 2, at least 2.
- `IDLE_TICKS`, 320, number of `EN_clk` ticks without a new byte before the timeout fires (2 characters at 16x oversampling).

Ports:
- `sys_clk`  in  1  the single clock; all logic is on its rising edge.
- `sys_rstH`  in  1  reset, asynchronous, active-high.
- `enableH`  in  1  run enable for the receiver timing.
- `baud_divH`  in  DIV_W  divisor; tick period is `baud_divH`+1 `sys_clk` cycles.
- `EN_clk`  out  1  one-cycle oversample tick to the receiver.
- `rec_dataH`  in  8  received byte from the receiver.
- `rec_readyH`  in  1  one-cycle strobe; `rec_dataH` is valid on this cycle.
- `rd_reqH`  in  1  consumer pop request.
- `rd_dataH`  out  8  FIFO head byte (FWFT).
- `rd_validH`  out  1  FIFO not empty.
- `countH`  out  log2(DEPTH)+1  FIFO occupancy.
- `overrunH`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `clr_errH`  in  1  clears `overrunH`.
- `flushH`  in  1  empties the FIFO.
- `idle_toH`  out  1  one-cycle pulse when the idle timeout expires.

## Operation

Baud divider:
- `div_cnt` is DIV_W bits wide.
- When `enableH`=1: if `div_cnt` >= `baud_divH`, then `EN_clk`<=1 and `div_cnt`<=0. Otherwise `EN_clk`<=0 and `div_cnt`+1.
- The `>=` compare covers a divisor reduced mid-count; there is no wrap-around.
- When `enableH`=0: `div_cnt`<=0 and `EN_clk`<=0.
- `baud_divH`=0 gives a tick every cycle.

FIFO:
- Circular buffer of DEPTH bytes, with write and read pointers of log2(DEPTH) bits that wrap naturally. The count is held separately.
- Push happens when `rec_readyH`=1 and not `flushH`.
  - If count<DEPTH, write at the write pointer.
  - If full and no pop in the same cycle, drop the byte and set `overrunH`.
- Pop happens when `rd_reqH`=1, `rd_validH`=1 and not `flushH`. `rd_reqH` while empty is ignored.
- Push and pop in the same cycle:
  - Both succeed and count is unchanged.
  - When full, no overrun is raised.
  - When empty, only the push happens.
- `flushH`=1: pointers and count go to 0. A push in the same cycle is discarded. Has priority over push and pop.
- `overrunH` update priority: set (push while full) > `clr_errH` clear. A cycle with both set and clear leaves the flag at 1.
- `enableH`=0 does not block pushes. A strobe already in flight is still captured.

Idle-timeout FSM (tick counter sized for IDLE_TICKS):
- T_IDLE: timer held at 0. A successful push moves to T_ARMED with timer 0.
- T_ARMED:
  - On `EN_clk`, timer+1.
  - A new successful push clears the timer and stays in T_ARMED.
  - When timer reaches IDLE_TICKS-1 together with `EN_clk`, move to T_FIRE.
- T_FIRE: `idle_toH`=1 for exactly this cycle, then T_IDLE.
  - If a push occurs in this cycle, the pulse is still emitted and the next state is T_ARMED.
- `enableH`=0 or `flushH`=1 from any state: next state T_IDLE, timer 0, no pulse.

Reset (`sys_rstH`=1, any time, including mid-byte or mid-count):
- All state clears asynchronously: FSM to T_IDLE, divider, pointers and count to 0.
- Output values during reset: `EN_clk`=0, `rd_validH`=0, `countH`=0, `overrunH`=0, `idle_toH`=0.
- `rd_dataH` reads the storage at pointer 0. It is don't-care while `rd_validH`=0.
- The storage array itself need not be reset.

## Timing

- `EN_clk`, `countH`, `rd_validH`, `overrunH` and `idle_toH` are all registered.
- Push latency: strobe in cycle N gives `rd_validH`=1 and `rd_dataH`=byte in cycle N+1.
- Pop: `rd_reqH` in cycle N updates the head and count in cycle N+1. `rd_dataH` is combinational from the head storage entry.
- First `EN_clk` after `enableH` rises (with `div_cnt` at 0) arrives `baud_divH`+1 cycles later.
- `idle_toH` is asserted one cycle after the `EN_clk` that completes IDLE_TICKS.

## Test plan

- Divider:
  - `baud_divH`=3: `EN_clk` is high every 4th cycle.
  - Change to 1 while `div_cnt`=2: tick on the next cycle, then every 2nd cycle.
  - `enableH`=0: `EN_clk` held at 0.
- Fill and drain: push 0x11, 0x22, 0x33, 0x44 → count=4. Pop four times → 0x11..0x44 in order, then `rd_validH`=0. Pointers wrap correctly on a second pass.
- Overrun: with 4 bytes in the FIFO, push 0x55 → dropped, `overrunH`=1, count=4. Push and pop in one cycle while full → no drop, count=4. `clr_errH` → 0.
- Idle timeout: `IDLE_TICKS`=8, `baud_divH`=0.
  - Push 0xA5 → `idle_toH` pulses once, 9 cycles later.
  - Push again after 5 ticks → timer restarts.
  - `flushH` while armed → no pulse.
- Flush and reset: a flush coinciding with a push leaves count=0. Asserting `sys_rstH` mid-run clears all outputs immediately, with no clock edge needed.
